// File: rtl/cpu_subsys_mem_arb.sv
// Two-master round-robin arbiter in front of the CPU subsystem SRAM.
// Master 0 is the CPU, master 1 is the DMA/debug master. Each access takes
// IDLE (arbitrate) -> ACCESS (downstream request) -> DONE (ready pulse).
// A watchdog aborts an access the slave stalls for TIMEOUT cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0_* / m1_*               master request (valid/addr/wdata/wstrb) and
//                             response (ready pulse, rdata)
//   s_*                       registered downstream request, s_ready/s_rdata in
//   grant                     current or last owner (0 = m0, 1 = m1)
//   timeout_err               sticky abort flag, cleared only by rst
module cpu_subsys_mem_arb #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        timeout_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_nxt;
  logic            last_grant, last_grant_nxt;
  logic            grant_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            timeout_err_nxt;
  logic            s_valid_nxt;
  logic [AW-1:0]   s_addr_nxt;
  logic [DW-1:0]   s_wdata_nxt;
  logic [SW-1:0]   s_wstrb_nxt;
  logic            m0_ready_nxt, m1_ready_nxt;
  logic [DW-1:0]   m0_rdata_nxt, m1_rdata_nxt;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      s_valid     <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_wstrb     <= '0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      grant       <= grant_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= timeout_err_nxt;
      s_valid     <= s_valid_nxt;
      s_addr      <= s_addr_nxt;
      s_wdata     <= s_wdata_nxt;
      s_wstrb     <= s_wstrb_nxt;
      m0_ready    <= m0_ready_nxt;
      m1_ready    <= m1_ready_nxt;
      m0_rdata    <= m0_rdata_nxt;
      m1_rdata    <= m1_rdata_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    logic          win;
    logic          finish;
    logic [DW-1:0] rsp;

    state_nxt       = state;
    last_grant_nxt  = last_grant;
    grant_nxt       = grant;
    cnt_nxt         = cnt;
    timeout_err_nxt = timeout_err;
    s_valid_nxt     = s_valid;
    s_addr_nxt      = s_addr;
    s_wdata_nxt     = s_wdata;
    s_wstrb_nxt     = s_wstrb;
    m0_ready_nxt    = 1'b0;
    m1_ready_nxt    = 1'b0;
    m0_rdata_nxt    = '0;
    m1_rdata_nxt    = '0;
    win             = 1'b0;
    finish          = 1'b0;
    rsp             = '0;

    unique case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          // On a tie the master not granted last wins
          win         = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
          grant_nxt   = win;
          cnt_nxt     = '0;
          s_valid_nxt = 1'b1;
          s_addr_nxt  = win ? m1_addr  : m0_addr;
          s_wdata_nxt = win ? m1_wdata : m0_wdata;
          s_wstrb_nxt = win ? m1_wstrb : m0_wstrb;
          state_nxt   = ACCESS;
        end
      end

      ACCESS: begin
        // s_ready takes priority over the watchdog in the same cycle
        if (s_ready) begin
          rsp    = s_rdata;
          finish = 1'b1;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rsp             = ERR_DATA;
          timeout_err_nxt = 1'b1;
          finish          = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end

        // The rdata flop of the owner doubles as the response register
        if (finish) begin
          s_valid_nxt = 1'b0;
          state_nxt   = DONE;
          if (grant) begin
            m1_ready_nxt = 1'b1;
            m1_rdata_nxt = rsp;
          end else begin
            m0_ready_nxt = 1'b1;
            m0_rdata_nxt = rsp;
          end
        end
      end

      DONE: begin
        last_grant_nxt = grant;
        state_nxt      = IDLE;
      end

      default: begin
        state_nxt   = IDLE;
        s_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/cpu_subsys_mem_arb.md
Name:
cpu_subsys_mem_arb

Overview:
- Two-master, one-slave arbiter sharing the CPU subsystem SRAM between the CPU (master 0) and a DMA or debug master (master 1).
- Uses the valid/ready/addr/wdata/wstrb/rdata memory bus on every port.
- Grants round-robin, registers the downstream request, returns read data registered, and aborts stalled accesses with a watchdog.

Parameters:
- TIMEOUT, 16: cycles an access may wait for s_ready before it is aborted. Legal range 2..255.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned to the master on an aborted access.

Ports:
- clk  input  1  clock; every flop is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- m0_valid / m1_valid  input  1  master request; held high until that master's ready pulse.
- m0_ready / m1_ready  output  1  one-cycle completion pulse to the granted master.
- m0_addr / m1_addr  input  32  byte address.
- m0_wdata / m1_wdata  input  32  write data.
- m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 means read.
- m0_rdata / m1_rdata  output  32  read data, valid with the ready pulse.
- s_valid  output  1  downstream request.
- s_ready  input  1  downstream accept/complete.
- s_addr  output  32  registered address.
- s_wdata  output  32  registered write data.
- s_wstrb  output  4  registered write strobes.
- s_rdata  input  32  downstream read data, sampled when s_valid and s_ready are both high.
- grant  output  1  current or last owner: 0 = m0, 1 = m1.
- timeout_err  output  1  sticky flag, set on any abort; cleared only by rst.

Behaviour:
- Reset values: all outputs 0; state IDLE; last-grant register = 1, so m0 wins the first tie.
- rst mid-access: next cycle s_valid = 0, no ready pulse, the access is dropped.
- FSM, state IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both request: grant the master not granted last.
  - On grant: latch addr/wdata/wstrb from the winner into s_*, set grant, clear the watchdog counter, go to ACCESS.
- FSM, state ACCESS:
  - s_valid = 1; s_addr, s_wdata, s_wstrb are stable throughout.
  - s_ready = 1: capture s_rdata into the response register, go to DONE.
  - s_ready = 0: increment the counter. When the counter reaches TIMEOUT-1 with s_ready still 0, load ERR_DATA into the response register, set timeout_err, go to DONE.
  - s_ready wins over timeout in the same cycle.
- FSM, state DONE:
  - s_valid = 0.
  - The granted master's ready = 1 for exactly this cycle; its rdata = response register.
  - The other master's ready = 0 and its rdata = 0.
  - Update last-grant; go to IDLE.
- Latency: request sampled in IDLE at edge T; s_valid high in cycle T+1. With a zero-wait slave (s_ready tied 1), m_ready pulses in cycle T+2, giving 3 cycles per access including the IDLE turnaround.
- Back-to-back requests: a master whose valid stays high after its ready pulse is a new request in the following IDLE cycle and competes normally, so both masters alternate fairly under continuous load.
- Writes: complete identically to reads. rdata on a write is don't-care, but the response register is still loaded from s_rdata.
- A master's valid must not drop before its ready pulse. If it does, the arbiter still completes the access it has already latched.
- Outputs m*_rdata, m*_ready, s_* and grant all come directly from flops.

Test Plan:
- Reset, m0 read at 0x0000_0010, s_ready tied 1, s_rdata 0x1234_5678 -> s_valid in cycle T+1 with s_addr 0x10 and s_wstrb 0; m0_ready pulses once in T+2 with m0_rdata 0x1234_5678; m1_ready stays 0.
- m0 and m1 request together after reset, then both hold valid continuously -> grant sequence 0,1,0,1; each master's ready occurs every 6 cycles.
- m1 write, addr 0x20, wdata 0xAABBCCDD, wstrb 4'b0101 -> s_wstrb 0101 and s_wdata 0xAABBCCDD held stable while s_valid is high; exactly one m1_ready pulse.
- s_ready held 0, TIMEOUT=16, m0 read -> s_valid high for 16 cycles, then m0_ready with m0_rdata 0xDEADBEEF; timeout_err = 1 and stays 1 across later good accesses.
- s_ready asserted in the same cycle the counter reaches TIMEOUT-1 -> normal completion with s_rdata returned; timeout_err stays 0.
- rst asserted during ACCESS -> next cycle all outputs 0; no ready pulse; a new m0 request then completes normally with grant = 0.
